// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NREQ requesters.
// Up to two grants per cycle, same-address hazards held back, read data routed home via tags.
module dpram_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [NREQ*DATA_W-1:0]   rdata,
  output logic                     ram_we1,
  output logic                     ram_we2,
  output logic [ADDR_W-1:0]        ram_adr1,
  output logic [ADDR_W-1:0]        ram_adr2,
  output logic [DATA_W-1:0]        ram_data1,
  output logic [DATA_W-1:0]        ram_data2,
  input  logic [DATA_W-1:0]        ram_q1,
  input  logic [DATA_W-1:0]        ram_q2
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1'b1);

  // Index (base + k) modulo NREQ, k in 0..NREQ.
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    s = (s >= NREQ) ? (s - NREQ) : s;
    return s[PW-1:0];
  endfunction

  logic [PW-1:0]     r_ptr;
  logic              r_p1_s1_v, r_p1_s2_v, r_p2_s1_v, r_p2_s2_v;
  logic [PW-1:0]     r_p1_s1_id, r_p1_s2_id, r_p2_s1_id, r_p2_s2_id;
  logic              w_a_vld, w_b_vld, w_b_gnt, w_conflict, w_a_we, w_b_we;
  logic [PW-1:0]     w_a_id, w_b_id, w_last_id, w_id;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr;
  logic [DATA_W-1:0] w_a_wdata, w_b_wdata;
  logic [NREQ-1:0]   w_a_oh, w_b_oh;

  // Rotating scan from r_ptr: first active requester is A (port 1), second is B (port 2).
  always_comb begin
    w_a_vld = 1'b0;
    w_a_id  = '0;
    w_b_vld = 1'b0;
    w_b_id  = '0;
    w_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_id    = rot(r_ptr, k);
      w_b_id  = (req[w_id] && w_a_vld && !w_b_vld) ? w_id : w_b_id;
      w_b_vld = w_b_vld | (req[w_id] & w_a_vld);
      w_a_id  = (req[w_id] && !w_a_vld) ? w_id : w_a_id;
      w_a_vld = w_a_vld | req[w_id];
    end
  end

  assign w_a_we    = req_we[w_a_id];
  assign w_b_we    = req_we[w_b_id];
  assign w_a_addr  = req_addr[w_a_id*ADDR_W +: ADDR_W];
  assign w_b_addr  = req_addr[w_b_id*ADDR_W +: ADDR_W];
  assign w_a_wdata = req_wdata[w_a_id*DATA_W +: DATA_W];
  assign w_b_wdata = req_wdata[w_b_id*DATA_W +: DATA_W];

  // B waits when it touches A's address and either side writes.
  assign w_conflict = w_b_vld && (w_a_addr == w_b_addr) && (w_a_we || w_b_we);
  assign w_b_gnt    = w_b_vld && !w_conflict;
  assign w_last_id  = w_b_gnt ? w_b_id : w_a_id;
  assign w_a_oh     = w_a_vld ? (ONE_HOT0 << w_a_id) : '0;
  assign w_b_oh     = w_b_gnt ? (ONE_HOT0 << w_b_id) : '0;
  assign gnt        = rst_n ? (w_a_oh | w_b_oh) : '0;

  // Pointer, registered RAM controls (idle ports hold address/data) and read-tag pipelines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      ram_we1    <= 1'b0;
      ram_we2    <= 1'b0;
      ram_adr1   <= '0;
      ram_adr2   <= '0;
      ram_data1  <= '0;
      ram_data2  <= '0;
      r_p1_s1_v  <= 1'b0;
      r_p1_s2_v  <= 1'b0;
      r_p2_s1_v  <= 1'b0;
      r_p2_s2_v  <= 1'b0;
      r_p1_s1_id <= '0;
      r_p1_s2_id <= '0;
      r_p2_s1_id <= '0;
      r_p2_s2_id <= '0;
    end else begin
      r_ptr      <= w_a_vld ? rot(w_last_id, 1) : r_ptr;
      ram_we1    <= w_a_vld & w_a_we;
      ram_adr1   <= w_a_vld ? w_a_addr : ram_adr1;
      ram_data1  <= w_a_vld ? w_a_wdata : ram_data1;
      ram_we2    <= w_b_gnt & w_b_we;
      ram_adr2   <= w_b_gnt ? w_b_addr : ram_adr2;
      ram_data2  <= w_b_gnt ? w_b_wdata : ram_data2;
      r_p1_s1_v  <= w_a_vld & ~w_a_we;
      r_p1_s1_id <= w_a_id;
      r_p1_s2_v  <= r_p1_s1_v;
      r_p1_s2_id <= r_p1_s1_id;
      r_p2_s1_v  <= w_b_gnt & ~w_b_we;
      r_p2_s1_id <= w_b_id;
      r_p2_s2_v  <= r_p2_s1_v;
      r_p2_s2_id <= r_p2_s1_id;
    end
  end

  // Return path: a valid stage-2 tag steers that port's RAM output to its requester.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = (r_p1_s2_v && (r_p1_s2_id == PW'(i))) ||
                  (r_p2_s2_v && (r_p2_s2_id == PW'(i)));
      rdata[i*DATA_W +: DATA_W] = (r_p1_s2_v && (r_p1_s2_id == PW'(i))) ? ram_q1 :
                                  (r_p2_s2_v && (r_p2_s2_id == PW'(i))) ? ram_q2 :
                                  {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM plus a queue-based arbitration model,
// directed scenarios followed by random traffic, all checked with immediate assertions.
module tb_dpram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, req_we, gnt, rvalid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata, rdata;
  logic              ram_we1, ram_we2;
  logic [AW-1:0]     ram_adr1, ram_adr2;
  logic [DW-1:0]     ram_data1, ram_data2, ram_q1, ram_q2;
  logic [AW-1:0]     t_addr [NREQ];
  logic [DW-1:0]     t_data [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[g*AW +: AW]  = t_addr[g];
    assign req_wdata[g*DW +: DW] = t_data[g];
  end

  dpram_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_we1(ram_we1), .ram_we2(ram_we2), .ram_adr1(ram_adr1), .ram_adr2(ram_adr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2), .ram_q1(ram_q1), .ram_q2(ram_q2)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Dual-port RAM with one-cycle registered read; contents seeded on the first edge.
  logic [DW-1:0] ram_mem [64];
  bit            ram_rdy;
  always @(posedge clk) begin
    if (!ram_rdy) begin
      for (int a = 0; a < 64; a++) ram_mem[a] <= init_val(a);
      ram_rdy <= 1'b1;
    end else begin
      if (ram_we1) ram_mem[ram_adr1] <= ram_data1;
      if (ram_we2) ram_mem[ram_adr2] <= ram_data2;
    end
    ram_q1 <= ram_mem[ram_adr1];
    ram_q2 <= ram_mem[ram_adr2];
  end

  // Reference model state
  int            checks, errors, m_ptr, m_a, m_b, max_wait;
  int            waitc [NREQ];
  logic [DW-1:0] m_mem [64];
  logic [NREQ-1:0] exp_gnt;
  logic          exp_we1, exp_we2;
  logic [AW-1:0] exp_adr1, exp_adr2;
  logic [DW-1:0] exp_dat1, exp_dat2;
  bit            d1_v [NREQ];
  bit            d2_v [NREQ];
  logic [DW-1:0] d1_d [NREQ];
  logic [DW-1:0] d2_d [NREQ];
  logic [NREQ-1:0] s_gnt, s_rvalid;
  logic [NREQ*DW-1:0] s_rdata;
  logic [AW-1:0] s_adr1, s_adr2;
  logic [1:0]    s_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    exp_we1 = 1'b0; exp_we2 = 1'b0;
    exp_adr1 = '0; exp_adr2 = '0; exp_dat1 = '0; exp_dat2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      d1_v[i] = 1'b0; d2_v[i] = 1'b0; d1_d[i] = '0; d2_d[i] = '0; waitc[i] = 0;
    end
  endtask

  task automatic model_eval();
    int order[$];
    exp_gnt = '0; m_a = -1; m_b = -1;
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++)
        if (req[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
      if (order.size() > 0) begin m_a = order[0]; exp_gnt[m_a] = 1'b1; end
      if (order.size() > 1) begin
        if (!(t_addr[order[1]] == t_addr[m_a] && (req_we[m_a] || req_we[order[1]]))) begin
          m_b = order[1]; exp_gnt[m_b] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NREQ; i++) begin
      d2_v[i] = d1_v[i]; d2_d[i] = d1_d[i]; d1_v[i] = 1'b0;
      if (req[i] && !exp_gnt[i]) waitc[i]++; else waitc[i] = 0;
      if (waitc[i] > max_wait) max_wait = waitc[i];
    end
    exp_we1 = 1'b0; exp_we2 = 1'b0;
    if (m_a >= 0) begin exp_we1 = req_we[m_a]; exp_adr1 = t_addr[m_a]; exp_dat1 = t_data[m_a]; end
    if (m_b >= 0) begin exp_we2 = req_we[m_b]; exp_adr2 = t_addr[m_b]; exp_dat2 = t_data[m_b]; end
    if (m_a >= 0 && !req_we[m_a]) begin d1_v[m_a] = 1'b1; d1_d[m_a] = m_mem[t_addr[m_a]]; end
    if (m_b >= 0 && !req_we[m_b]) begin d1_v[m_b] = 1'b1; d1_d[m_b] = m_mem[t_addr[m_b]]; end
    if (m_a >= 0 && req_we[m_a]) m_mem[t_addr[m_a]] = t_data[m_a];
    if (m_b >= 0 && req_we[m_b]) m_mem[t_addr[m_b]] = t_data[m_b];
    if (m_a >= 0) m_ptr = (((m_b >= 0) ? m_b : m_a) + 1) % NREQ;
  endtask

  // One clock: compare everything at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [NREQ-1:0] ev;
    @(negedge clk);
    model_eval();
    s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata;
    s_adr1 = ram_adr1; s_adr2 = ram_adr2; s_we = {ram_we2, ram_we1};
    chk("gnt", 64'(gnt), 64'(exp_gnt));
    for (int i = 0; i < NREQ; i++) ev[i] = d2_v[i];
    chk("rvalid", 64'(rvalid), 64'(ev));
    for (int i = 0; i < NREQ; i++)
      if (d2_v[i]) chk("rdata", 64'(rdata[i*DW +: DW]), 64'(d2_d[i]));
    chk("ram_we1", 64'(ram_we1), 64'(exp_we1));
    chk("ram_we2", 64'(ram_we2), 64'(exp_we2));
    chk("ram_adr1", 64'(ram_adr1), 64'(exp_adr1));
    chk("ram_adr2", 64'(ram_adr2), 64'(exp_adr2));
    chk("ram_data1", 64'(ram_data1), 64'(exp_dat1));
    chk("ram_data2", 64'(ram_data2), 64'(exp_dat2));
    @(posedge clk);
    if (rst_n) model_commit(); else model_reset();
    #1;
  endtask

  task automatic set_rq(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; req_we[i] = we; t_addr[i] = a; t_data[i] = d;
  endtask

  initial begin
    checks = 0; errors = 0; max_wait = 0;
    rst_n = 1'b0; req = 4'hF; req_we = '0;
    for (int i = 0; i < NREQ; i++) begin t_addr[i] = 6'(i); t_data[i] = '0; end
    for (int a = 0; a < 64; a++) m_mem[a] = init_val(a);
    model_reset();
    step(); step();
    chk("rst_gnt", 64'(s_gnt), 64'(4'h0));
    chk("rst_rvalid", 64'(s_rvalid), 64'(4'h0));
    chk("rst_rdata", 64'(s_rdata), 64'(32'h0));
    chk("rst_ram_we", 64'(s_we), 64'(2'b00));
    rst_n = 1'b1; req = '0;
    step();

    // Single write then read by requester 2
    set_rq(2, 1'b1, 6'h11, 8'hA5); step();
    chk("t1_wr_gnt", 64'(s_gnt), 64'(4'b0100));
    set_rq(2, 1'b0, 6'h11, 8'h00); step();
    chk("t1_rd_gnt", 64'(s_gnt), 64'(4'b0100));
    req = '0; step();
    chk("t1_no_early_rvalid", 64'(s_rvalid), 64'(4'b0000));
    step();
    chk("t1_rvalid", 64'(s_rvalid), 64'(4'b0100));
    chk("t1_rdata", 64'(s_rdata[23:16]), 64'(8'hA5));

    // Dual grant: preload 0x03/0x04 then read both in one cycle
    set_rq(0, 1'b1, 6'h03, 8'h30); set_rq(1, 1'b1, 6'h04, 8'h40); step();
    chk("t2_wr_gnt", 64'(s_gnt), 64'(4'b0011));
    set_rq(0, 1'b0, 6'h03, 8'h00); set_rq(1, 1'b0, 6'h04, 8'h00); step();
    chk("t2_rd_gnt", 64'(s_gnt), 64'(4'b0011));
    req = '0; step();
    chk("t2_adr1", 64'(s_adr1), 64'(6'h03));
    chk("t2_adr2", 64'(s_adr2), 64'(6'h04));
    step();
    chk("t2_rvalid", 64'(s_rvalid), 64'(4'b0011));
    chk("t2_rdata0", 64'(s_rdata[7:0]), 64'(8'h30));
    chk("t2_rdata1", 64'(s_rdata[15:8]), 64'(8'h40));

    // Conflict: move ptr to 0, then write/read same address
    set_rq(3, 1'b0, 6'h05, 8'h00); step(); req = '0;
    set_rq(0, 1'b1, 6'h20, 8'h77); set_rq(1, 1'b0, 6'h20, 8'h00); step();
    chk("t3_gnt_c", 64'(s_gnt), 64'(4'b0001));
    req[0] = 1'b0; step();
    chk("t3_gnt_c1", 64'(s_gnt), 64'(4'b0010));
    req = '0; step(); step();
    chk("t3_rvalid", 64'(s_rvalid), 64'(4'b0010));
    chk("t3_rdata1", 64'(s_rdata[15:8]), 64'(8'h77));

    // Round-robin with all four holding reads
    set_rq(3, 1'b0, 6'h06, 8'h00); step(); req = '0;
    for (int i = 0; i < NREQ; i++) set_rq(i, 1'b0, 6'(8 + i), 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t4_rr_gnt", 64'(s_gnt), 64'((k % 2 == 0) ? 4'b0011 : 4'b1100));
    end
    req = '0; step(); step();

    // Wrap: ptr=3 with requesters 3 and 0
    set_rq(2, 1'b0, 6'h07, 8'h00); step(); req = '0;
    set_rq(3, 1'b0, 6'h0C, 8'h00); set_rq(0, 1'b0, 6'h0D, 8'h00); step();
    chk("t5_gnt", 64'(s_gnt), 64'(4'b1001));
    req = '0; step();
    chk("t5_adr1", 64'(s_adr1), 64'(6'h0C));
    chk("t5_adr2", 64'(s_adr2), 64'(6'h0D));
    for (int i = 0; i < 3; i++) set_rq(i, 1'b0, 6'(16 + i), 8'h00);
    step();
    chk("t5_ptr1_gnt", 64'(s_gnt), 64'(4'b0110));
    req = '0; step(); step(); step();

    // Reset the cycle after a read grant
    set_rq(1, 1'b0, 6'h14, 8'h00); step();
    chk("t6_gnt", 64'(s_gnt), 64'(4'b0010));
    rst_n = 1'b0; model_reset(); req = 4'hF; #1;
    chk("t6_gnt_forced", 64'(gnt), 64'(4'h0));
    chk("t6_rvalid", 64'(rvalid), 64'(4'h0));
    chk("t6_rdata", 64'(rdata), 64'(32'h0));
    chk("t6_ram_we", 64'({ram_we2, ram_we1}), 64'(2'b00));
    chk("t6_ram_adr", 64'({ram_adr2, ram_adr1}), 64'(12'h0));
    chk("t6_ram_data", 64'({ram_data2, ram_data1}), 64'(16'h0));
    step(); step();
    rst_n = 1'b1; req = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_no_rvalid", 64'(s_rvalid), 64'(4'h0));
      chk("t6_no_write", 64'(s_we), 64'(2'b00));
    end

    // Random traffic on a small address window to provoke conflicts
    max_wait = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 9) < 6)
          set_rq(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
      step();
      for (int i = 0; i < NREQ; i++) if (s_gnt[i]) req[i] = 1'b0;
    end
    req = '0; step(); step(); step();
    chk("fairness", 64'(max_wait <= NREQ - 1), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
